// File: rtl/cdu_pkg.sv
// Shared CDU definitions: increment-sender state, request direction and saturating arithmetic.
package cdu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StRelease,
    StGap
  } sender_state_e;

  typedef enum logic {
    DirPlus  = 1'b0,
    DirMinus = 1'b1
  } dir_e;

  // Symmetric clamp to +/-max_val; callers detect lost steps by comparing with the raw sum.
  function automatic int sat_add(input int a, input int b, input int max_val);
    int sum;
    sum = a + b;
    if (sum > max_val) begin
      return max_val;
    end
    if (sum < -max_val) begin
      return -max_val;
    end
    return sum;
  endfunction

endpackage

// File: rtl/slot_timer.sv
// Loadable down-counter used for both the inter-request gap and the acknowledge timeout.
module slot_timer #(
  parameter int unsigned WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             tick,
  output logic             expired
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (tick && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/agc_increment_sender.sv
// Queues read-counter steps in a signed backlog and forwards each one to the AGC as a
// PCDU/MCDU increment request using a four-phase handshake.
module agc_increment_sender
  import cdu_pkg::*;
#(
  parameter int unsigned BACKLOG_W   = 6,
  parameter int unsigned SLOT_GAP    = 16,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        up_step,
  input  logic                        dn_step,
  input  logic                        cdu_zero,
  input  logic                        agc_ack,
  output logic                        agc_pcdu_req,
  output logic                        agc_mcdu_req,
  output logic signed [BACKLOG_W-1:0] backlog,
  output logic                        busy,
  output logic                        overflow,
  output logic                        timeout_err
);

  localparam int          BacklogMax = (2 ** (BACKLOG_W - 1)) - 1;
  localparam int unsigned TimerMax   = (SLOT_GAP > ACK_TIMEOUT) ? SLOT_GAP : ACK_TIMEOUT;
  localparam int unsigned TimerW     = $clog2(TimerMax + 1);
  // Timer reaches zero on the last allowed cycle, hence the -1 on both loads.
  localparam logic [TimerW-1:0] AckLoad = TimerW'(ACK_TIMEOUT - 1);
  localparam logic [TimerW-1:0] GapLoad = TimerW'(SLOT_GAP - 1);

  sender_state_e               state_q;
  dir_e                        dir_q;
  logic signed [BACKLOG_W-1:0] backlog_q, backlog_d;
  logic                        pcdu_q, mcdu_q, overflow_q, timeout_q;
  logic                        step_lost;
  int                          sent, delta, raw_sum, sat_sum;

  logic              timer_load, timer_tick, timer_expired;
  logic [TimerW-1:0] timer_val;

  slot_timer #(
    .WIDTH(TimerW)
  ) u_slot_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (timer_load),
    .load_val(timer_val),
    .tick    (timer_tick),
    .expired (timer_expired)
  );

  always_comb begin
    sent = 0;
    if ((state_q == StReq) && agc_ack) begin
      sent = (dir_q == DirPlus) ? 1 : -1;
    end
    delta     = int'(up_step) - int'(dn_step) - sent;
    raw_sum   = int'(backlog_q) + delta;
    sat_sum   = sat_add(int'(backlog_q), delta, BacklogMax);
    step_lost = (raw_sum != sat_sum);
    backlog_d = BACKLOG_W'(sat_sum);
  end

  always_comb begin
    timer_load = 1'b0;
    timer_tick = 1'b0;
    timer_val  = '0;
    unique case (state_q)
      StIdle: begin
        if (backlog_q != '0) begin
          timer_load = 1'b1;
          timer_val  = AckLoad;
        end
      end
      StReq: begin
        if (!agc_ack) begin
          if (timer_expired) begin
            timer_load = 1'b1;
            timer_val  = GapLoad;
          end else begin
            timer_tick = 1'b1;
          end
        end
      end
      StRelease: begin
        if (!agc_ack) begin
          timer_load = 1'b1;
          timer_val  = GapLoad;
        end
      end
      StGap:   timer_tick = 1'b1;
      default: timer_tick = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || cdu_zero) begin
      state_q    <= StIdle;
      dir_q      <= DirPlus;
      backlog_q  <= '0;
      pcdu_q     <= 1'b0;
      mcdu_q     <= 1'b0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      backlog_q <= backlog_d;
      if (step_lost) begin
        overflow_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (backlog_q > 0) begin
            dir_q   <= DirPlus;
            pcdu_q  <= 1'b1;
            state_q <= StReq;
          end else if (backlog_q < 0) begin
            dir_q   <= DirMinus;
            mcdu_q  <= 1'b1;
            state_q <= StReq;
          end
        end
        StReq: begin
          if (agc_ack) begin
            pcdu_q  <= 1'b0;
            mcdu_q  <= 1'b0;
            state_q <= StRelease;
          end else if (timer_expired) begin
            pcdu_q    <= 1'b0;
            mcdu_q    <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= StGap;
          end
        end
        StRelease: begin
          if (!agc_ack) begin
            state_q <= StGap;
          end
        end
        StGap: begin
          if (timer_expired) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign agc_pcdu_req = pcdu_q;
  assign agc_mcdu_req = mcdu_q;
  assign backlog      = backlog_q;
  assign busy         = (state_q != StIdle);
  assign overflow     = overflow_q;
  assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_agc_increment_sender.sv
// Directed self-checking bench for agc_increment_sender with a delayed AGC ack responder.
module tb_agc_increment_sender;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              up_step = 1'b0;
  logic              dn_step = 1'b0;
  logic              cdu_zero = 1'b0;
  logic              agc_ack;
  logic              agc_pcdu_req, agc_mcdu_req, busy, overflow, timeout_err;
  logic signed [5:0] backlog;

  logic auto_en = 1'b0;
  logic ack_man = 1'b0;
  logic ack_auto = 1'b0;
  logic req_d1 = 1'b0;

  int errors = 0;
  int checks = 0;

  // Monitor state
  logic pcdu_prev = 1'b0, mcdu_prev = 1'b0, req_prev = 1'b0, seen_req = 1'b0;
  int   pcdu_cnt = 0, mcdu_cnt = 0, idle_run = 0, min_gap = 1000, high_run = 0, last_len = 0;

  always #5 clk = ~clk;

  assign agc_ack = auto_en ? ack_auto : ack_man;

  agc_increment_sender #(
    .BACKLOG_W  (6),
    .SLOT_GAP   (16),
    .ACK_TIMEOUT(64)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .up_step     (up_step),
    .dn_step     (dn_step),
    .cdu_zero    (cdu_zero),
    .agc_ack     (agc_ack),
    .agc_pcdu_req(agc_pcdu_req),
    .agc_mcdu_req(agc_mcdu_req),
    .backlog     (backlog),
    .busy        (busy),
    .overflow    (overflow),
    .timeout_err (timeout_err)
  );

  // AGC responder: ack follows the request level two cycles late
  always @(posedge clk) begin
    req_d1   <= agc_pcdu_req | agc_mcdu_req;
    ack_auto <= req_d1;
  end

  always @(posedge clk) begin
    pcdu_prev <= agc_pcdu_req;
    mcdu_prev <= agc_mcdu_req;
    req_prev  <= agc_pcdu_req | agc_mcdu_req;
    if (agc_pcdu_req && !pcdu_prev) pcdu_cnt <= pcdu_cnt + 1;
    if (agc_mcdu_req && !mcdu_prev) mcdu_cnt <= mcdu_cnt + 1;
    if (agc_pcdu_req | agc_mcdu_req) begin
      if (!req_prev && seen_req && (idle_run < min_gap)) min_gap <= idle_run;
      seen_req <= 1'b1;
      idle_run <= 0;
    end else begin
      idle_run <= idle_run + 1;
    end
    if (agc_pcdu_req) begin
      high_run <= high_run + 1;
    end else if (high_run != 0) begin
      last_len <= high_run;
      high_run <= 0;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while (!((busy == 1'b0) && (backlog == 0)) && (n < bound)) begin
      cyc(1);
      n++;
    end
    check(tag, int'(n < bound), 1);
  endtask

  task automatic wait_pcdu(input string tag, input int bound, input logic level);
    int n = 0;
    while ((agc_pcdu_req != level) && (n < bound)) begin
      cyc(1);
      n++;
    end
    check(tag, int'(n < bound), 1);
  endtask

  int p0, m0;

  initial begin
    cyc(3);
    check("rst_backlog", int'(backlog), 0);
    check("rst_pcdu", int'(agc_pcdu_req), 0);
    check("rst_mcdu", int'(agc_mcdu_req), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_flags", int'({overflow, timeout_err}), 0);
    rst_n = 1'b1;
    cyc(2);

    // 1: three up steps, auto-acked as three PCDU handshakes
    auto_en = 1'b1;
    p0 = pcdu_cnt;
    m0 = mcdu_cnt;
    up_step = 1'b1;
    cyc(3);
    up_step = 1'b0;
    check("t1_busy", int'(busy), 1);
    wait_idle("t1_drain", 300);
    check("t1_pcdu_cnt", pcdu_cnt - p0, 3);
    check("t1_mcdu_cnt", mcdu_cnt - m0, 0);
    check("t1_backlog", int'(backlog), 0);

    // 2: direction stays latched while backlog changes sign
    auto_en = 1'b0;
    ack_man = 1'b0;
    up_step = 1'b1;
    cyc(1);
    up_step = 1'b0;
    wait_pcdu("t2_req_up", 10, 1'b1);
    dn_step = 1'b1;
    cyc(3);
    dn_step = 1'b0;
    check("t2_backlog_mid", int'(backlog), -2);
    check("t2_pcdu_held", int'(agc_pcdu_req), 1);
    check("t2_mcdu_low", int'(agc_mcdu_req), 0);
    ack_man = 1'b1;
    cyc(1);
    ack_man = 1'b0;
    check("t2_backlog_ack", int'(backlog), -3);
    check("t2_pcdu_drop", int'(agc_pcdu_req), 0);
    cyc(3);
    auto_en = 1'b1;
    p0 = pcdu_cnt;
    m0 = mcdu_cnt;
    wait_idle("t2_drain", 300);
    check("t2_mcdu_cnt", mcdu_cnt - m0, 3);
    check("t2_pcdu_cnt", pcdu_cnt - p0, 0);
    check("t12_min_gap_ok", int'(min_gap >= 16), 1);

    // 3: simultaneous up/dn cancel
    up_step = 1'b1;
    dn_step = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      check("t3_backlog", int'(backlog), 0);
      check("t3_busy", int'(busy), 0);
    end
    up_step = 1'b0;
    dn_step = 1'b0;
    cyc(2);

    // 4: saturation and acknowledge timeout
    auto_en = 1'b0;
    ack_man = 1'b0;
    up_step = 1'b1;
    cyc(40);
    up_step = 1'b0;
    check("t4_backlog_sat", int'(backlog), 31);
    check("t4_overflow", int'(overflow), 1);
    check("t4_pcdu_high", int'(agc_pcdu_req), 1);
    check("t4_no_timeout_yet", int'(timeout_err), 0);
    wait_pcdu("t4_pcdu_drop", 100, 1'b0);
    cyc(2);
    check("t4_req_len", last_len, 64);
    check("t4_timeout_err", int'(timeout_err), 1);
    check("t4_backlog_kept", int'(backlog), 31);
    check("t4_overflow_sticky", int'(overflow), 1);

    // 5: cdu_zero clears flags, then aborts a request with backlog 5
    cdu_zero = 1'b1;
    cyc(1);
    cdu_zero = 1'b0;
    check("t5_clr_backlog", int'(backlog), 0);
    check("t5_clr_flags", int'({overflow, timeout_err}), 0);
    check("t5_clr_busy", int'(busy), 0);
    up_step = 1'b1;
    cyc(5);
    up_step = 1'b0;
    check("t5_backlog5", int'(backlog), 5);
    check("t5_in_req", int'(agc_pcdu_req), 1);
    cdu_zero = 1'b1;
    up_step  = 1'b1;
    cyc(1);
    cdu_zero = 1'b0;
    up_step  = 1'b0;
    check("t5_abort_reqs", int'({agc_pcdu_req, agc_mcdu_req}), 0);
    check("t5_abort_backlog", int'(backlog), 0);
    check("t5_abort_busy", int'(busy), 0);
    check("t5_abort_flags", int'({overflow, timeout_err}), 0);
    cyc(3);
    check("t5_stays_idle", int'({busy, agc_pcdu_req}), 0);

    // 6: reset while in RELEASE with ack high
    up_step = 1'b1;
    cyc(2);
    up_step = 1'b0;
    check("t6_req", int'(agc_pcdu_req), 1);
    ack_man = 1'b1;
    cyc(1);
    check("t6_release_backlog", int'(backlog), 1);
    check("t6_release_busy", int'(busy), 1);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    check("t6_rst_backlog", int'(backlog), 0);
    check("t6_rst_outs", int'({agc_pcdu_req, agc_mcdu_req, busy, overflow, timeout_err}), 0);
    cyc(5);
    check("t6_ack_ignored_backlog", int'(backlog), 0);
    check("t6_ack_ignored_outs", int'({agc_pcdu_req, agc_mcdu_req, busy}), 0);
    ack_man = 1'b0;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
